// File: rtl/llr_t2s_pipe.sv
// Two-stage, multi-lane converter: two's-complement LLR lanes to {sign, magnitude}, optional clamp.
// Two cycles from input handshake to out_valid; holds out_data while out_ready is low.

module llr_t2s_pipe #(
    parameter int DATA_WIDTH = 6,
    parameter int MAG_WIDTH  = 6,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]      in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*(MAG_WIDTH+1)-1:0]   out_data,
    output logic [LANES-1:0]                 out_sat,
    output logic [CNT_WIDTH-1:0]             sat_count,
    input  logic                             clr_count
);

    localparam int AW = DATA_WIDTH + 1;
    localparam int OW = MAG_WIDTH + 1;
    localparam int PW = $clog2(LANES + 1);
    localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

    localparam logic [AW-1:0]        MAG_MAX = {{(AW-MAG_WIDTH){1'b0}}, {MAG_WIDTH{1'b1}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                         r_s1_valid;
    logic [LANES-1:0]             r_s1_sign;
    logic [LANES-1:0][AW-1:0]     r_s1_abs;

    logic                         r_out_valid;
    logic [LANES*OW-1:0]          r_out_data;
    logic [LANES-1:0]             r_out_sat;
    logic [CNT_WIDTH-1:0]         r_sat_count;

    logic                         w_adv1;
    logic                         w_adv2;
    logic                         w_out_hs;
    logic [LANES-1:0]             w_sign;
    logic [LANES-1:0][AW-1:0]     w_abs;
    logic [LANES-1:0]             w_sat;
    logic [LANES*OW-1:0]          w_lane_dat;
    logic [PW-1:0]                w_pop;
    logic [CNT_WIDTH-1:0]         w_cnt_base;
    logic [SW-1:0]                w_sum;
    logic [CNT_WIDTH-1:0]         w_cnt_nxt;

    assign w_adv2   = !r_out_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign w_out_hs = r_out_valid && out_ready;

    assign in_ready  = w_adv1;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign sat_count = r_sat_count;

    // Negate at one extra bit so the most negative input has a representable magnitude.
    for (genvar i = 0; i < LANES; i++) begin : g_abs
        logic [DATA_WIDTH-1:0] w_lane_in;
        logic [AW-1:0]         w_ext;

        assign w_lane_in = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_ext     = {w_lane_in[DATA_WIDTH-1], w_lane_in};
        assign w_sign[i] = w_lane_in[DATA_WIDTH-1];
        assign w_abs[i]  = w_sign[i] ? (~w_ext + AW'(1)) : w_ext;
    end

    // A set sign always comes with a nonzero magnitude, so negative zero cannot appear.
    for (genvar i = 0; i < LANES; i++) begin : g_clamp
        logic [MAG_WIDTH-1:0] w_mag;

        assign w_sat[i] = (r_s1_abs[i] > MAG_MAX);
        assign w_mag    = w_sat[i] ? MAG_MAX[MAG_WIDTH-1:0] : r_s1_abs[i][MAG_WIDTH-1:0];
        assign w_lane_dat[i*OW +: OW] = {r_s1_sign[i], w_mag};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= '0;
            r_s1_abs   <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= w_sign;
            r_s1_abs   <= w_abs;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            r_out_data  <= w_lane_dat;
            r_out_sat   <= w_sat;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop = w_pop + PW'(r_out_sat[i]);
        end
    end

    // Clear takes effect first, so a beat delivered in the clear cycle starts the new count.
    always_comb begin
        w_cnt_base = clr_count ? '0 : r_sat_count;
        w_sum      = SW'(w_cnt_base) + SW'(w_pop);
        w_cnt_nxt  = w_cnt_base;
        if (w_out_hs) begin
            w_cnt_nxt = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (clr_count || w_out_hs) begin
            r_sat_count <= w_cnt_nxt;
        end
    end

endmodule

// File: doc/llr_t2s_pipe.md
Name: llr_t2s_pipe

Overview:
- Multi-lane, pipelined converter from two's-complement LLR messages to sign-magnitude, with valid/ready flow control.
- Optional magnitude saturation to a narrower width, with per-lane saturation flags and a saturation event counter.
- Sits between variable-node adders (two's complement) and min-sum check-node logic (sign-magnitude).

Parameters:
- DATA_WIDTH, 6, width of each two's-complement input lane.
- MAG_WIDTH, 6, magnitude width of each output lane; must be 1..DATA_WIDTH. When MAG_WIDTH < DATA_WIDTH, magnitudes saturate.
- LANES, 4, number of independent lanes per beat.
- CNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, block can accept an input beat.
- in_data, input, LANES*DATA_WIDTH, lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the output beat.
- out_data, output, LANES*(MAG_WIDTH+1), lane i occupies bits [i*(MAG_WIDTH+1) +: MAG_WIDTH+1] as {sign, magnitude}.
- out_sat, output, LANES, bit i set means lane i of the current out_data was clamped.
- sat_count, output, CNT_WIDTH, running count of saturated lanes delivered.
- clr_count, input, 1, synchronous clear of sat_count.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - s1_valid, out_valid and sat_count are cleared to 0.
  - out_data and out_sat are cleared to 0.
  - Reset mid-operation discards all in-flight beats, with no partial output.
- Stage 1 (per lane):
  - sign = in[DATA_WIDTH-1].
  - abs = sign ? (~in + 1) : in, computed at DATA_WIDTH+1 bits, so -2^(DATA_WIDTH-1) yields 2^(DATA_WIDTH-1) without overflow.
  - sign and abs are registered.
- Stage 2 (per lane):
  - If abs > 2^MAG_WIDTH-1: magnitude = 2^MAG_WIDTH-1 and sat bit = 1.
  - Otherwise: magnitude = abs[MAG_WIDTH-1:0] and sat bit = 0.
  - Output lane = {sign, magnitude}, registered into out_data/out_sat.
  - Sign is preserved on saturation.
  - Zero input gives {0, 0}; negative zero is never produced.
- Pipeline control:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1; this is a combinational path from out_ready and is permitted.
  - Stage 1 loads when adv1. In that case s1_valid <= in_valid.
  - Stage 2 loads when adv2. In that case out_valid <= s1_valid.
  - Stage registers hold their value while the stage is not advancing.
- Throughput and latency:
  - Throughput is one beat per cycle when out_ready is held high.
  - Latency is 2 cycles from an input handshake to out_valid.
- Backpressure:
  - While out_valid && !out_ready, out_data and out_sat stay stable.
  - With both stages full, in_ready = 0.
  - No beat is dropped or duplicated.
  - Ordering is strictly FIFO.
- sat_count:
  - On an output handshake (out_valid && out_ready), sat_count is incremented by popcount(out_sat).
  - The counter saturates at 2^CNT_WIDTH-1 and does not wrap.
  - clr_count and a handshake in the same cycle: sat_count <= popcount(out_sat) of that beat.
  - clr_count with no handshake: sat_count <= 0.
- Lanes are fully independent; each lane's sign and saturation depend only on its own input.

Test Plan:
- Conversion, DATA_WIDTH=6, MAG_WIDTH=6, LANES=4: in lanes {-6, +5, 0, -1} = {111010, 000101, 000000, 111111} -> out lanes {1_000110, 0_000101, 0_000000, 1_000001}, out_sat=0000, out_valid 2 cycles after the handshake.
- Most negative, MAG_WIDTH=6: lane -32 (100000) -> 1_100000 with no saturation.
- Most negative, MAG_WIDTH=5: lane -32 (100000) -> 1_11111 with sat=1; lane +31 -> 0_11111 with sat=0; lane -31 -> 1_11111 with sat=0.
- Backpressure: stream 10 beats with out_ready toggling 1,0,0,1 -> all 10 beats delivered in order, out_data stable while stalled, in_ready=0 when both stages are full.
- Counter: MAG_WIDTH=5, CNT_WIDTH=3, 3 beats each with 3 saturated lanes -> sat_count 3, 6, 7 (saturates).
- Counter clear: clr_count asserted together with a beat having 2 saturated lanes -> sat_count=2.
- Reset mid-stream: rst_n=0 for 1 cycle with both stages full -> out_valid=0, sat_count=0, out_data=0 next cycle; the next accepted beat appears 2 cycles after its handshake.
